// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 4-stage core: shadow scoreboard of in-flight writers,
// stall/bubble/flush generation, debug-halt latching and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_reg_write,
  input  logic [1:0]       dec_debug,
  input  logic             jump_taken,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             bubble_exec,
  output logic             flush_fetch,
  output logic             flush_decode,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HAZARD = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [1:0] flush_left;
  logic [1:0] cause_q;

  logic       ex_v, ex_we, mem_v, mem_we, wb_v, wb_we;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  logic       hazard;
  logic       haz_stall;
  logic       debug_req;

  function automatic logic slot_match(input logic v, input logic we,
                                      input logic [4:0] rd, input logic [4:0] rs);
    return v & we & (rd != 5'd0) & (rd == rs);
  endfunction

  function automatic logic reg_busy(input logic [4:0] rs);
    logic busy;
    busy = slot_match(ex_v, ex_we, ex_rd, rs) | slot_match(mem_v, mem_we, mem_rd, rs);
    if (WB_BYPASS == 0)
      busy = busy | slot_match(wb_v, wb_we, wb_rd, rs);
    return busy;
  endfunction

  always_comb begin
    hazard = dec_valid & ((dec_rs1_used & reg_busy(dec_rs1)) |
                          (dec_rs2_used & reg_busy(dec_rs2)));
  end

  assign debug_req = dec_valid & (dec_debug != 2'b00);

  // Priority inside RUN/HAZARD: jump (older instruction) > hazard > debug event.
  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    bubble_exec  = 1'b0;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    halted       = 1'b0;
    haz_stall    = 1'b0;
    if (!rst_n) begin
      stall_fetch  = 1'b1;
      stall_decode = 1'b1;
    end else begin
      case (state)
        S_HALT: begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          bubble_exec  = 1'b1;
          halted       = 1'b1;
        end
        S_FLUSH: begin
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
        end
        default: begin
          if (jump_taken) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
          end else if (hazard) begin
            haz_stall    = 1'b1;
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            bubble_exec  = 1'b1;
          end else if (debug_req) begin
            bubble_exec  = 1'b1;
          end
        end
      endcase
    end
  end

  assign halt_cause = rst_n ? cause_q : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      flush_left  <= 2'd0;
      cause_q     <= 2'b00;
      ex_v        <= 1'b0;
      ex_we       <= 1'b0;
      ex_rd       <= 5'd0;
      mem_v       <= 1'b0;
      mem_we      <= 1'b0;
      mem_rd      <= 5'd0;
      wb_v        <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state != S_HALT) begin
        wb_v   <= mem_v;
        wb_we  <= mem_we;
        wb_rd  <= mem_rd;
        mem_v  <= ex_v;
        mem_we <= ex_we;
        mem_rd <= ex_rd;
        // A bubbled or squashed Decode slot enters Exec as a non-writer.
        ex_v   <= dec_valid & ~bubble_exec & ~flush_decode;
        ex_we  <= dec_reg_write;
        ex_rd  <= dec_rd;
        if (haz_stall && (stall_count != {CNT_W{1'b1}}))
          stall_count <= stall_count + 1'b1;
        if (flush_decode && (flush_count != {CNT_W{1'b1}}))
          flush_count <= flush_count + 1'b1;
      end

      case (state)
        S_RUN, S_HAZARD: begin
          if (jump_taken) begin
            state      <= (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
            flush_left <= FLUSH_LOAD;
          end else if (hazard) begin
            state <= S_HAZARD;
          end else if (debug_req) begin
            state   <= S_HALT;
            cause_q <= dec_debug;
          end else begin
            state <= S_RUN;
          end
        end
        S_FLUSH: begin
          // flush_left counts FLUSH cycles remaining including this one.
          flush_left <= flush_left - 2'd1;
          if (flush_left <= 2'd1)
            state <= S_RUN;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 4-stage core (Fetch, Decode, Exec, Mem).
- Keeps a shadow scoreboard of in-flight register writers, because the core has no forwarding network.
- Drives stall, bubble and flush controls to the stages, and latches debug halts reported by Decode.
- Counts stall and flush cycles for performance checks in simulation.

Parameters:
- WB_BYPASS, 1: 1 = register file is write-through (the write-back slot is not a hazard); 0 = write-back slot also causes a stall.
- FLUSH_CYCLES, 1: cycles of squash after a taken jump/branch (1..3).
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- dec_valid  in  1  Decode holds a real (non-bubble) instruction
- dec_rs1  in  5  rs1 index of the Decode instruction
- dec_rs2  in  5  rs2 index of the Decode instruction
- dec_rs1_used  in  1  instruction reads rs1
- dec_rs2_used  in  1  instruction reads rs2
- dec_rd  in  5  destination index of the Decode instruction
- dec_reg_write  in  1  instruction writes rd
- dec_debug  in  2  DebugStatus from Decode (OK=00, BREAK=01, FAIL=10)
- jump_taken  in  1  Exec output jump_enable (redirect valid this cycle)
- stall_fetch  out  1  Fetch holds its PC and instruction register
- stall_decode  out  1  Decode holds its output registers
- bubble_exec  out  1  Exec latches a NOP (reg_write, mem_load and mem_store forced to 0)
- flush_fetch  out  1  Fetch output is squashed to a NOP
- flush_decode  out  1  Decode output is squashed to a NOP
- halted  out  1  core frozen by a debug event
- halt_cause  out  2  DebugStatus that caused the halt (00 while running)
- stall_count  out  CNT_W  saturating count of hazard-stall cycles
- flush_count  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=RUN; all scoreboard slots invalid; counters=0; halt_cause=00.
  - All control outputs are 0, except stall_fetch=stall_decode=1 while rst_n=0.
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {v, rd, we}.
  - Every edge not in HALT: WB<=MEM, MEM<=EX.
  - EX<={dec_valid & dec_reg_write, dec_rd}. It is loaded as invalid when bubble_exec or flush_decode is asserted.
- A slot "matches" rs when v & we & rd!=0 & rd==rs.
- hazard (combinational) = dec_valid & (rs1_used & match(rs1) | rs2_used & match(rs2)).
  - Slots checked: EX and MEM; WB also when WB_BYPASS=0.
  - x0 never causes a hazard.
- Outputs are combinational from current state and inputs.
- Priority: HALT > flush > hazard.
- States:
  - RUN:
    - jump_taken: flush_fetch=flush_decode=1, stall_*=0. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
    - else hazard: stall_fetch=stall_decode=bubble_exec=1. Go to HAZARD.
    - else dec_debug!=OK and dec_valid: go to HALT and latch halt_cause. The halting instruction is not forwarded (bubble_exec=1 this cycle).
  - HAZARD:
    - Same hazard evaluation every cycle; stay while hazard=1.
    - Leave for RUN in the cycle hazard=0. Outputs drop that same cycle and the instruction issues.
    - A jump_taken here overrides the stall (the older jump wins) and squashes the stalled instruction.
  - FLUSH:
    - flush_fetch=flush_decode=1 for FLUSH_CYCLES total cycles (down-counter), then return to RUN.
    - A new jump_taken during FLUSH is ignored.
  - HALT:
    - stall_fetch=stall_decode=bubble_exec=1 and halted=1. Scoreboard is frozen.
    - Only reset exits.
    - Exec/Mem have already drained by design, because bubbles keep entering.
- Latency: a dependent instruction entering Decode the cycle after its producer waits 2 stall cycles with WB_BYPASS=1, and 3 with WB_BYPASS=0. A producer two instructions ahead costs 1 stall cycle.
- Counters: stall_count increments in each cycle with hazard-stall asserted (not HALT). flush_count increments in each cycle with flush_decode=1. Both saturate at all-ones.
- Reset asserted mid-stall, mid-flush or in HALT returns everything to the reset values at that edge.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with jump_taken=1 -> flush_*=0, halted=0, counters 0. After release, state is RUN with no stall.
- RAW, back-to-back: issue addi x5 then add x6,x5,x1 (WB_BYPASS=1) -> stall_decode=1 and bubble_exec=1 for exactly 2 cycles, stall_count=2; x6 reads the correct x5.
- x0 and unused operands: producer rd=0 followed by a reader of x0, and a reader with rs2_used=0 matching an in-flight rd -> no stall, stall_count unchanged.
- Jump during hazard: while in HAZARD, assert jump_taken for 1 cycle -> flush_fetch=flush_decode=1 that cycle, stall_*=0, flush_count=1, state RUN. With FLUSH_CYCLES=2 -> flush held 2 cycles, flush_count=2.
- Breakpoint: Decode presents dec_debug=01 with dec_valid=1 -> next cycle halted=1, halt_cause=01, all stalls high indefinitely. rst_n=0 clears it.
- Saturation: force 2^CNT_W+5 hazard cycles (CNT_W=4) -> stall_count stays 15.
